// File: rtl/reg_file.sv
// Parametrised register file: two registered read ports, one write port with
// same-cycle read-after-write bypass, optional hardwired zero register and a
// one-register-per-cycle clear sweep.
module reg_file #(
  parameter int WORD_SIZE = 16,
  parameter int NIB_SIZE  = 4,
  parameter bit ZERO_REG  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NIB_SIZE-1:0]  num1,
  input  logic [NIB_SIZE-1:0]  num2,
  input  logic                 get_enable,
  input  logic [NIB_SIZE-1:0]  setnum,
  input  logic [WORD_SIZE-1:0] setval,
  input  logic                 set_enable,
  input  logic                 clear_enable,
  output logic [WORD_SIZE-1:0] out1,
  output logic [WORD_SIZE-1:0] out2,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int REG_STACK_SIZE = 2 ** NIB_SIZE;
  localparam logic [NIB_SIZE-1:0] LAST_IDX = NIB_SIZE'(REG_STACK_SIZE - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                state, next_state;
  logic [NIB_SIZE-1:0]   idx;
  logic [WORD_SIZE-1:0]  data [REG_STACK_SIZE];
  logic                  do_get;
  logic                  do_set;

  // Read value for register n as seen by a read issued this cycle: zero
  // register first, then the in-flight write, then the array.
  function automatic logic [WORD_SIZE-1:0] rd_byp(input logic [NIB_SIZE-1:0] n);
    if (ZERO_REG && n == '0)
      return '0;
    if (set_enable && n == setnum)
      return setval;
    return data[n];
  endfunction

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    do_get     = 1'b0;
    do_set     = 1'b0;
    case (state)
      IDLE: begin
        if (clear_enable) begin
          next_state = CLEAR;
        end else begin
          do_get = get_enable;
          do_set = set_enable && !(ZERO_REG && setnum == '0);
        end
      end
      CLEAR: begin
        if (idx == LAST_IDX)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR)
        idx <= idx + 1'b1;
      else
        idx <= '0;
    end
  end

  // NOTE: the array is reset on purpose: software relies on register i
  // holding i after reset, and a reset mid-sweep must restore that.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_STACK_SIZE; i++)
        data[i] <= (ZERO_REG && i == 0) ? '0 : WORD_SIZE'(i);
    end else if (state == CLEAR) begin
      data[idx] <= '0;
    end else if (do_set) begin
      data[setnum] <= setval;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out1      <= '0;
      out2      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= do_get;
      if (do_get) begin
        out1 <= rd_byp(num1);
        out2 <= rd_byp(num2);
      end
    end
  end

  assign busy = (state == CLEAR);

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a default instance and a ZERO_REG=1 instance
// share all inputs; each task drives one scenario and checks inline.
module tb_reg_file;

  logic        clk;
  logic        reset_n;
  logic [3:0]  num1, num2, setnum;
  logic [15:0] setval;
  logic        get_enable, set_enable, clear_enable;
  logic [15:0] out1, out2, zout1, zout2;
  logic        out_valid, busy, zout_valid, zbusy;

  int tests_run    = 0;
  int tests_failed = 0;

  reg_file dut (
    .clk(clk), .reset_n(reset_n), .num1(num1), .num2(num2),
    .get_enable(get_enable), .setnum(setnum), .setval(setval),
    .set_enable(set_enable), .clear_enable(clear_enable),
    .out1(out1), .out2(out2), .out_valid(out_valid), .busy(busy)
  );

  reg_file #(.ZERO_REG(1'b1)) dut_z (
    .clk(clk), .reset_n(reset_n), .num1(num1), .num2(num2),
    .get_enable(get_enable), .setnum(setnum), .setval(setval),
    .set_enable(set_enable), .clear_enable(clear_enable),
    .out1(zout1), .out2(zout2), .out_valid(zout_valid), .busy(zbusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    get_enable   = 1'b0;
    set_enable   = 1'b0;
    clear_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    num1 = '0; num2 = '0; setnum = '0; setval = '0;
    idle_inputs();
    #3;
    tests_run++;
    if (out1 !== 16'h0 || out2 !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_out: got %h/%h expected 0000/0000", out1, out2);
    end
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || zbusy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got valid=%b busy=%b zbusy=%b expected 0/0/0", out_valid, busy, zbusy);
    end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_read();
    get_enable = 1'b1; num1 = 4'd3; num2 = 4'd15;
    step();
    tests_run++;
    if (out1 !== 16'h3 || out2 !== 16'hf || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_default: got %h/%h v=%b expected 0003/000f v=1", out1, out2, out_valid);
    end
    get_enable = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || out1 !== 16'h3) begin
      tests_failed++;
      $display("FAIL read_valid_drop: got v=%b out1=%h expected v=0 out1=0003", out_valid, out1);
    end
  endtask

  task automatic test_bypass();
    set_enable = 1'b1; setnum = 4'd5; setval = 16'hBEEF;
    get_enable = 1'b1; num1 = 4'd5; num2 = 4'd6;
    step();
    tests_run++;
    if (out1 !== 16'hBEEF || out2 !== 16'h6) begin
      tests_failed++;
      $display("FAIL bypass: got %h/%h expected beef/0006", out1, out2);
    end
    // plain write with no read, then read through the array next cycle
    get_enable = 1'b0; setnum = 4'd9; setval = 16'h1357;
    step();
    set_enable = 1'b0; get_enable = 1'b1; num1 = 4'd5; num2 = 4'd9;
    step();
    tests_run++;
    if (out1 !== 16'hBEEF || out2 !== 16'h1357) begin
      tests_failed++;
      $display("FAIL write_array: got %h/%h expected beef/1357", out1, out2);
    end
    get_enable = 1'b0;
    step();
  endtask

  task automatic test_zero_reg();
    set_enable = 1'b1; setnum = 4'd0; setval = 16'h1234;
    get_enable = 1'b1; num1 = 4'd0; num2 = 4'd1;
    step();
    tests_run++;
    if (zout1 !== 16'h0 || zout2 !== 16'h1) begin
      tests_failed++;
      $display("FAIL zero_same_cycle: got %h/%h expected 0000/0001", zout1, zout2);
    end
    tests_run++;
    if (out1 !== 16'h1234) begin
      tests_failed++;
      $display("FAIL nonzero_r0_bypass: got %h expected 1234", out1);
    end
    set_enable = 1'b0;
    step();
    tests_run++;
    if (zout1 !== 16'h0 || zout2 !== 16'h1 || zout_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_next_cycle: got %h/%h v=%b expected 0000/0001 v=1", zout1, zout2, zout_valid);
    end
    tests_run++;
    if (out1 !== 16'h1234) begin
      tests_failed++;
      $display("FAIL nonzero_r0_array: got %h expected 1234", out1);
    end
    get_enable = 1'b0;
    step();
  endtask

  // Steps until busy drops; a timeout counts as a failure.
  task automatic wait_not_busy(input string name);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_timeout: got busy=%b expected 0 within 40 cycles", name, busy);
    end
  endtask

  task automatic test_clear();
    int  cycles   = 0;
    bit  saw_valid = 1'b0;
    clear_enable = 1'b1;
    step();
    clear_enable = 1'b0;
    get_enable = 1'b1; num1 = 4'd7; num2 = 4'd7;
    set_enable = 1'b1; setnum = 4'd7; setval = 16'hAAAA;
    while (busy && cycles < 40) begin
      cycles++;
      if (out_valid) saw_valid = 1'b1;
      step();
    end
    idle_inputs();
    tests_run++;
    if (cycles != 16) begin
      tests_failed++;
      $display("FAIL clear_busy_len: got %0d cycles expected 16", cycles);
    end
    tests_run++;
    if (saw_valid || out1 !== 16'h1234) begin
      tests_failed++;
      $display("FAIL clear_ignores_get: got valid_seen=%b out1=%h expected 0/1234", saw_valid, out1);
    end
    get_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      num1 = 4'(i); num2 = 4'(15 - i);
      step();
      tests_run++;
      if (out1 !== 16'h0 || out2 !== 16'h0) begin
        tests_failed++;
        $display("FAIL cleared_reg_%0d: got %h/%h expected 0000/0000", i, out1, out2);
      end
    end
    get_enable = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    clear_enable = 1'b1;
    step();
    clear_enable = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy: got %b expected 0 without an edge", busy);
    end
    step();
    reset_n = 1'b1;
    get_enable = 1'b1; num1 = 4'd10; num2 = 4'd2;
    step();
    tests_run++;
    if (out1 !== 16'ha || out2 !== 16'h2) begin
      tests_failed++;
      $display("FAIL abort_restore: got %h/%h expected 000a/0002", out1, out2);
    end
    get_enable = 1'b0;
    step();
  endtask

  task automatic test_clear_priority();
    clear_enable = 1'b1;
    set_enable = 1'b1; setnum = 4'd4; setval = 16'h5555;
    get_enable = 1'b1; num1 = 4'd4; num2 = 4'd4;
    step();
    idle_inputs();
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || out1 !== 16'ha) begin
      tests_failed++;
      $display("FAIL priority_start: got v=%b busy=%b out1=%h expected 0/1/000a", out_valid, busy, out1);
    end
    wait_not_busy("priority");
    get_enable = 1'b1; num1 = 4'd4; num2 = 4'd9;
    step();
    tests_run++;
    if (out1 !== 16'h0 || out2 !== 16'h0) begin
      tests_failed++;
      $display("FAIL priority_no_write: got %h/%h expected 0000/0000", out1, out2);
    end
    get_enable = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    clear_enable = 1'b1;
    step();
    wait_not_busy("b2b_first");
    step();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_rearm: got busy=%b expected 1", busy);
    end
    clear_enable = 1'b0;
    wait_not_busy("b2b_second");
  endtask

  initial begin
    test_reset();
    test_read();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_abort();
    test_clear_priority();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised register file, the successor to the fixed 16×16 register stack in the CPU datapath. It provides two registered read ports and one write port with same-cycle read-after-write bypass. An optional hardwired-zero register 0 is available. A cycle-by-cycle clear engine replaces the single-cycle bulk reset. It sits between instruction decode, which supplies register numbers, and the ALU/writeback stage, which consumes `out1`/`out2` and drives `setval`.

## Interface
- `WORD_SIZE`, 16: register width in bits.
- `NIB_SIZE`, 4: register-number width. Depth is `REG_STACK_SIZE` = 2**`NIB_SIZE`.
- `ZERO_REG`, 0: when 1, register 0 reads as 0 and writes to it are discarded.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `num1`, `num2` input `NIB_SIZE`: read register numbers.
- `get_enable` input 1: read request.
- `setnum` input `NIB_SIZE`: write register number.
- `setval` input `WORD_SIZE`: write data.
- `set_enable` input 1: write request.
- `clear_enable` input 1: start a clear sweep (pulse or level).
- `out1`, `out2` output `WORD_SIZE`: registered read data.
- `out_valid` output 1: `out1`/`out2` updated by the previous edge's read.
- `busy` output 1: a clear sweep is in progress.

## Operation
- Reset (`reset_n`=0, asynchronous):
  - `data[i]` = i, zero-extended to `WORD_SIZE`. If `ZERO_REG`=1, `data[0]`=0.
  - `out1` = `out2` = 0; `out_valid` = 0; `busy` = 0; sweep index = 0.
- State machine has two states, IDLE and CLEAR.
- IDLE:
  - `get_enable`=1: on the edge, `out1` <= `rd(num1)`, `out2` <= `rd(num2)`, `out_valid` <= 1. Otherwise `out_valid` <= 0 and `out1`/`out2` hold.
  - `set_enable`=1: on the edge, `data[setnum]` <= `setval`. The write is discarded when `ZERO_REG`=1 and `setnum`=0.
  - Get and set in the same cycle: both are performed; they are no longer exclusive.
  - Bypass: if `num1`==`setnum` in that cycle, `out1` takes `setval`. `num2` is handled the same way. Bypass is suppressed for register 0 when `ZERO_REG`=1, which returns 0.
  - `clear_enable`=1: go to CLEAR, `busy` <= 1, index <= 0. In that cycle `clear_enable` has priority: get and set are ignored and `out_valid` <= 0.
- CLEAR:
  - Each edge writes `data[index]` <= 0 and increments index.
  - After the edge that writes index `REG_STACK_SIZE`-1: `busy` <= 0, return to IDLE, index wraps to 0.
  - `get_enable`, `set_enable` and `clear_enable` are ignored. `out_valid` = 0; `out1`/`out2` hold.
- `rd(n)`: 0 if `ZERO_REG`=1 and n=0; otherwise `data[n]`.
- Index arithmetic is `NIB_SIZE` bits wide. Termination uses the index value, not a carry.

## Timing
- Read latency: 1 cycle. Data requested at edge N is on `out1`/`out2` after edge N, with `out_valid`=1 for exactly that cycle unless the read is repeated.
- Write latency: 1 cycle. A write at edge N is visible through the array to a read issued at edge N+1, and to a same-cycle read via bypass.
- Clear sweep: `clear_enable` sampled at edge N gives `busy`=1 after edge N. Register i is cleared at edge N+1+i. `busy`=0 after edge N+`REG_STACK_SIZE`. The sweep occupies `REG_STACK_SIZE`+1 edges including the start edge.
- Back-to-back clear: `clear_enable` held high re-arms on the first IDLE edge after `busy` falls.
- Reset during a sweep aborts it immediately. Registers not yet cleared return to their index values. `busy` = 0 asynchronously.
- No combinational path from any input to any output.

## Test plan
- Reset release with defaults, `get_enable`, `num1`=3, `num2`=15 -> one edge later `out1`=16'h3, `out2`=16'hf, `out_valid`=1. Next idle cycle -> `out_valid`=0.
- `set_enable`, `setnum`=5, `setval`=16'hBEEF together with `get_enable`, `num1`=5, `num2`=6 -> `out1`=16'hBEEF (bypass), `out2`=16'h6. A later read of 5 -> 16'hBEEF.
- `ZERO_REG`=1: write 16'h1234 to register 0, then read 0 both in the same cycle and the next cycle -> `out1`=0 both times. Register 1 is unaffected (16'h1).
- `clear_enable` pulse at edge N -> `busy` high for exactly 16 cycles. Gets and sets issued during the sweep are ignored (`out_valid`=0, a set of 7 := 16'hAAAA is lost). After the sweep, reads of 0..15 all return 0.
- Assert `reset_n` low at sweep edge N+5 -> `busy`=0 immediately, no edge needed. After release, reg 10 reads 16'ha and reg 2 reads 16'h2.
- Simultaneous `clear_enable`, `set_enable` (`setnum`=4, 16'h5555) and `get_enable` in IDLE -> clear wins, no write, `out_valid`=0. Post-sweep read of reg 4 -> 0.
